// File: rtl/msgq_fifo_reader.sv
// Read-side adapter for the message-queue FIFO: two-word prefetch buffer feeding a
// valid/ready stream, with header/payload framing and a saturating message counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// S_HDR | head word (when valid) is a message header; len field = payload size
// S_PAY | head word is payload; rem = payload words still to be popped
module msgq_fifo_reader #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_first,
  output logic              m_last,
  output logic [CNT_W-1:0]  msg_count,
  output logic              busy
);

  typedef enum logic {S_HDR, S_PAY} state_t;

  localparam logic [LEN_W:0]   REM_ONE = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [LEN_W:0]    rem;
  logic [1:0]        occ;
  logic              inflight;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;
  logic [2:0]        credit;
  logic              pop;
  logic              msg_done;
  logic [LEN_W-1:0]  hdr_len;

  assign pop      = m_valid & m_ready;
  assign credit   = {1'b0, occ} + {2'b00, inflight};
  // A read may be issued into a full credit only when a pop frees a slot this cycle.
  assign fifo_rd_en = ~rst & ~fifo_empty &
                      ((credit < 3'd2) | ((credit == 3'd2) & pop));

  assign m_valid  = (occ != 2'd0);
  assign m_data   = buf0;
  assign hdr_len  = buf0[LEN_W-1:0];
  assign m_first  = m_valid & (state == S_HDR);
  assign m_last   = m_valid & ((state == S_HDR) ? (hdr_len == '0) : (rem == REM_ONE));
  assign msg_done = pop & m_last;
  assign busy     = (state == S_PAY) | m_valid | inflight;

  // buf0 is always the head; buf1 holds the second word when occ == 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_dout;
          else             buf1 <= fifo_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= fifo_dout;
          end else begin
            buf0 <= buf1;
            buf1 <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HDR;
      rem   <= '0;
    end else if (pop) begin
      case (state)
        S_HDR: begin
          if (hdr_len != '0) begin
            rem   <= {1'b0, hdr_len};
            state <= S_PAY;
          end
        end
        S_PAY: begin
          rem <= rem - REM_ONE;
          if (rem == REM_ONE) state <= S_HDR;
        end
        default: state <= S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_count <= '0;
    end else if (msg_done && (msg_count != CNT_MAX)) begin
      msg_count <= msg_count + CNT_ONE;
    end
  end

endmodule
